// File: rtl/galvo_dac_spi.sv
`timescale 1ns/1ps
// galvo_dac_spi: shifts one (x, y) point as two 16-bit MCP4922 frames, then pulses LDAC.
// Build option LASER_SYNC_EN: laser colour updates with the LDAC pulse instead of on accept.
module galvo_dac_spi #(
  parameter int SCLK_DIV     = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int LATCH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] pt_x,
  input  logic [11:0] pt_y,
  input  logic [2:0]  pt_rgb,
  input  logic        pt_valid,
  output logic        pt_ready,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_csn,
  output logic        dac_latchn,
  output logic [2:0]  laser_rgb,
  output logic        busy
);

  localparam int PH_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > LATCH_CYCLES) ? GAP_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FRAME_A,
    GAP_A,
    FRAME_B,
    GAP_B,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      word_a_q, word_a_d;
  logic [15:0]      word_b_q, word_b_d;
  logic [3:0]       bit_q, bit_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             high_q, high_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       laser_q, laser_d;
`ifdef LASER_SYNC_EN
  logic [2:0]       rgb_q, rgb_d;
`endif
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             csn_q, csn_d;
  logic             latchn_q, latchn_d;

  logic             accept;
  logic             phase_end;
  logic             frame_done;
  logic             in_frame_d;
  logic [15:0]      shift_word_d;
  logic [3:0]       bit_idx_d;

  always_comb begin
    accept     = pt_valid && pt_ready;
    phase_end  = (phase_q == PH_LAST);
    frame_done = phase_end && high_q && (bit_q == 4'd15);

    state_d  = state_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    bit_d    = bit_q;
    phase_d  = phase_q;
    high_d   = high_q;
    cnt_d    = cnt_q;
    laser_d  = laser_q;
`ifdef LASER_SYNC_EN
    rgb_d    = rgb_q;
`endif

    case (state_q)
      IDLE: begin
        if (accept) begin
          word_a_d = {4'b0111, pt_x};
          word_b_d = {4'b1111, pt_y};
`ifdef LASER_SYNC_EN
          rgb_d    = pt_rgb;
`else
          laser_d  = pt_rgb;
`endif
          bit_d    = '0;
          phase_d  = '0;
          high_d   = 1'b0;
          state_d  = FRAME_A;
        end
      end

      FRAME_A, FRAME_B: begin
        if (phase_end) begin
          phase_d = '0;
          high_d  = ~high_q;
          if (high_q) begin
            bit_d = bit_q + 4'd1;
          end
          // Leave before the bit counter would wrap; sclk drops with CS.
          if (frame_done) begin
            bit_d   = '0;
            high_d  = 1'b0;
            cnt_d   = '0;
            state_d = (state_q == FRAME_A) ? GAP_A : GAP_B;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      GAP_A: begin
        if (cnt_q == GAP_LAST) begin
          bit_d   = '0;
          phase_d = '0;
          high_d  = 1'b0;
          state_d = FRAME_B;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP_B: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = LATCH;
`ifdef LASER_SYNC_EN
          laser_d = rgb_q;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pins are registered from the next-state decode: glitch-free, same cycle timing as the state.
  always_comb begin
    in_frame_d   = (state_d == FRAME_A) || (state_d == FRAME_B);
    shift_word_d = (state_d == FRAME_B) ? word_b_d : word_a_d;
    bit_idx_d    = 4'd15 - bit_d;
    csn_d        = !in_frame_d;
    sclk_d       = in_frame_d && high_d;
    mosi_d       = in_frame_d && shift_word_d[bit_idx_d];
    latchn_d     = (state_d != LATCH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      word_a_q <= '0;
      word_b_q <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      high_q   <= 1'b0;
      cnt_q    <= '0;
      laser_q  <= '0;
`ifdef LASER_SYNC_EN
      rgb_q    <= '0;
`endif
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      csn_q    <= 1'b1;
      latchn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      high_q   <= high_d;
      cnt_q    <= cnt_d;
      laser_q  <= laser_d;
`ifdef LASER_SYNC_EN
      rgb_q    <= rgb_d;
`endif
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      csn_q    <= csn_d;
      latchn_q <= latchn_d;
    end
  end

  always_comb begin
    pt_ready   = (state_q == IDLE) && !reset;
    busy       = (state_q != IDLE);
    dac_sclk   = sclk_q;
    dac_mosi   = mosi_q;
    dac_csn    = csn_q;
    dac_latchn = latchn_q;
    laser_rgb  = laser_q;
  end

endmodule

// File: tb/tb_galvo_dac_spi.sv
`timescale 1ns/1ps
// Bench for galvo_dac_spi: default instance plus a minimum-timing instance (div/gap/latch = 1).
module tb_galvo_dac_spi;

  localparam int DIV0 = 2, GAP0 = 2, LAT0 = 2;
  localparam int DIV1 = 1, GAP1 = 1, LAT1 = 1;

  typedef struct {
    int          inst;
    logic [15:0] wa;
    logic [15:0] wb;
    logic [2:0]  rgb;
    logic [2:0]  old_laser;
    int          t0;
  } txn_t;

  logic        clk;
  logic        reset;
  logic [11:0] pt_x       [2];
  logic [11:0] pt_y       [2];
  logic [2:0]  pt_rgb     [2];
  logic        pt_valid   [2];
  logic        pt_ready   [2];
  logic        dac_sclk   [2];
  logic        dac_mosi   [2];
  logic        dac_csn    [2];
  logic        dac_latchn [2];
  logic [2:0]  laser_rgb  [2];
  logic        busy       [2];

  galvo_dac_spi u_dut0 (
    .clk(clk), .reset(reset),
    .pt_x(pt_x[0]), .pt_y(pt_y[0]), .pt_rgb(pt_rgb[0]), .pt_valid(pt_valid[0]),
    .pt_ready(pt_ready[0]), .dac_sclk(dac_sclk[0]), .dac_mosi(dac_mosi[0]),
    .dac_csn(dac_csn[0]), .dac_latchn(dac_latchn[0]), .laser_rgb(laser_rgb[0]),
    .busy(busy[0])
  );

  galvo_dac_spi #(.SCLK_DIV(DIV1), .GAP_CYCLES(GAP1), .LATCH_CYCLES(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .pt_x(pt_x[1]), .pt_y(pt_y[1]), .pt_rgb(pt_rgb[1]), .pt_valid(pt_valid[1]),
    .pt_ready(pt_ready[1]), .dac_sclk(dac_sclk[1]), .dac_mosi(dac_mosi[1]),
    .dac_csn(dac_csn[1]), .dac_latchn(dac_latchn[1]), .laser_rgb(laser_rgb[1]),
    .busy(busy[1])
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  txn_t        sb [$];

  logic        prev_csn    [2];
  logic        prev_sclk   [2];
  logic        prev_latchn [2];
  logic [2:0]  prev_laser  [2];
  logic [15:0] sr          [2];
  bit          in_frame    [2];
  int          fidx        [2];
  int          edges       [2];
  int          fstart      [2];
  int          last_rise   [2];
  int          sclk_rises  [2];
  int          sclk_stray  [2];
  int          latch_falls [2];
  int          last_t0     [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic mon_step(input int i);
    int          d, g, l;
    bit          have;
    txn_t        t;
    txn_t        nt;
    logic [15:0] w;
    d    = div_of(i);
    g    = gap_of(i);
    l    = lat_of(i);
    have = (sb.size() > 0) && (sb[0].inst == i);
    if (have) t = sb[0];
    w = (fidx[i] == 0) ? t.wa : t.wb;

    if (reset) begin
      for (int k = sb.size() - 1; k >= 0; k--)
        if (sb[k].inst == i) sb.delete(k);
      in_frame[i] = 1'b0;
      fidx[i]     = 0;
    end else begin
      if (prev_csn[i] && !dac_csn[i]) begin
        if (!have) check_eq("sb_empty_frame", 0, 1);
        else begin
          check_eq("frame_start", cyc - t.t0, 1 + fidx[i] * (32 * d + g));
          check_eq("mosi_msb", dac_mosi[i], w[15]);
          check_eq("sclk_low_at_cs", dac_sclk[i], 0);
          check_eq("busy_in_frame", busy[i], 1);
          if (fidx[i] == 0) begin
`ifdef LASER_SYNC_EN
            check_eq("laser_held", laser_rgb[i], t.old_laser);
`else
            check_eq("laser_early", laser_rgb[i], t.rgb);
`endif
          end
        end
        in_frame[i] = 1'b1;
        edges[i]    = 0;
        sr[i]       = '0;
        fstart[i]   = cyc;
      end

      if (!prev_sclk[i] && dac_sclk[i]) begin
        sclk_rises[i]++;
        if (dac_csn[i]) sclk_stray[i]++;
        else if (in_frame[i]) begin
          if (edges[i] > 0) check_eq("sclk_period", cyc - last_rise[i], 2 * d);
          else              check_eq("sclk_first_rise", cyc - fstart[i], d);
          sr[i]        = {sr[i][14:0], dac_mosi[i]};
          edges[i]     = edges[i] + 1;
          last_rise[i] = cyc;
        end
      end

      if (prev_sclk[i] && !dac_sclk[i] && in_frame[i])
        check_eq("sclk_high_len", cyc - last_rise[i], d);

      if (!prev_csn[i] && dac_csn[i] && in_frame[i]) begin
        check_eq("edges_per_frame", edges[i], 16);
        check_eq("frame_len", cyc - fstart[i], 32 * d);
        if (have) check_eq((fidx[i] == 0) ? "frame_a_word" : "frame_b_word", sr[i], w);
        in_frame[i] = 1'b0;
        fidx[i]     = fidx[i] + 1;
      end

      if (prev_latchn[i] && !dac_latchn[i]) begin
        latch_falls[i]++;
        if (!have) check_eq("sb_empty_latch", 0, 1);
        else begin
          check_eq("latch_fall", cyc - t.t0, 1 + 64 * d + 2 * g);
          check_eq("csn_in_latch", dac_csn[i], 1);
          check_eq("laser_at_latch", laser_rgb[i], t.rgb);
`ifdef LASER_SYNC_EN
          check_eq("laser_pre_latch", prev_laser[i], t.old_laser);
`endif
        end
      end

      if (!prev_latchn[i] && dac_latchn[i]) begin
        if (!have) check_eq("sb_empty_done", 0, 1);
        else begin
          check_eq("latch_done", cyc - t.t0, 1 + 64 * d + 2 * g + l);
          check_eq("frames_done", fidx[i], 2);
          check_eq("ready_after", pt_ready[i], 1);
          check_eq("busy_after", busy[i], 0);
          void'(sb.pop_front());
        end
        fidx[i] = 0;
      end

      if (pt_valid[i] && pt_ready[i]) begin
        nt.inst      = i;
        nt.wa        = {4'h7, pt_x[i]};
        nt.wb        = {4'hF, pt_y[i]};
        nt.rgb       = pt_rgb[i];
        nt.old_laser = laser_rgb[i];
        nt.t0        = cyc;
        sb.push_back(nt);
        last_t0[i]   = cyc;
      end
    end

    prev_csn[i]    = dac_csn[i];
    prev_sclk[i]   = dac_sclk[i];
    prev_latchn[i] = dac_latchn[i];
    prev_laser[i]  = laser_rgb[i];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon_step(i);
  end

  task automatic offer(input int i, input logic [11:0] x, input logic [11:0] y,
                       input logic [2:0] rgb);
    int n = 0;
    pt_x[i]     = x;
    pt_y[i]     = y;
    pt_rgb[i]   = rgb;
    pt_valid[i] = 1'b1;
    @(negedge clk);
    while (!pt_ready[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_timeout", n < 400, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || busy[i]) && n < 400);
    check_eq("idle_timeout", n < 400, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, tp, lf, r0, n;
    for (int i = 0; i < 2; i++) begin
      pt_x[i] = '0; pt_y[i] = '0; pt_rgb[i] = '0; pt_valid[i] = 1'b0;
      in_frame[i] = 1'b0; fidx[i] = 0; edges[i] = 0; fstart[i] = 0;
      last_rise[i] = 0; sclk_rises[i] = 0; sclk_stray[i] = 0;
      latch_falls[i] = 0; last_t0[i] = 0; sr[i] = '0;
    end
    reset = 1'b1;

    repeat (3) @(negedge clk);
    check_eq("ready_in_reset", pt_ready[0], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_csn", dac_csn[0], 1);
    check_eq("rst_latchn", dac_latchn[0], 1);
    check_eq("rst_sclk", dac_sclk[0], 0);
    check_eq("rst_mosi", dac_mosi[0], 0);
    check_eq("rst_laser", laser_rgb[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("ready_after_rst", pt_ready[0], 1);
    check_eq("ready_after_rst1", pt_ready[1], 1);
    r0 = sclk_rises[0];
    repeat (200) @(negedge clk);
    check_eq("idle_sclk_toggles", sclk_rises[0] - r0, 0);
    check_eq("idle_busy", busy[0], 0);

    // Single point.
    @(posedge clk);
    #1;
    offer(0, 12'hABC, 12'h123, 3'b101);
    pt_valid[0] = 1'b0;
    wait_idle(0);

    // Valid held across three points; next point's data sits on the inputs mid-transaction.
    offer(0, 12'h001, 12'h800, 3'b010);
    tp = last_t0[0];
    offer(0, 12'h5A5, 12'hA5A, 3'b110);
    check_eq("b2b_interval_1", last_t0[0] - tp, 135);
    tp = last_t0[0];
    offer(0, 12'hFFF, 12'h000, 3'b001);
    check_eq("b2b_interval_2", last_t0[0] - tp, 135);
    pt_valid[0] = 1'b0;
    pt_x[0]     = 12'h555;
    pt_y[0]     = 12'h666;
    wait_idle(0);

    // Abort mid frame A.
    offer(0, 12'h3C3, 12'h0F0, 3'b111);
    pt_valid[0] = 1'b0;
    t0 = last_t0[0];
    n  = 0;
    while (cyc != t0 + 40 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("pre_abort_csn", dac_csn[0], 0);
    @(negedge clk);
    check_eq("abort_csn", dac_csn[0], 1);
    check_eq("abort_sclk", dac_sclk[0], 0);
    check_eq("abort_mosi", dac_mosi[0], 0);
    check_eq("abort_latchn", dac_latchn[0], 1);
    check_eq("abort_laser", laser_rgb[0], 0);
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_ready", pt_ready[0], 0);
    lf = latch_falls[0];
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("no_latch_after_abort", latch_falls[0], lf);
    check_eq("idle_after_abort", busy[0], 0);
    offer(0, 12'h7FF, 12'h800, 3'b011);
    pt_valid[0] = 1'b0;
    wait_idle(0);

    // Minimum timing instance: 67-cycle transaction, 68-cycle point rate.
    offer(1, 12'h9E7, 12'h018, 3'b001);
    tp = last_t0[1];
    offer(1, 12'h246, 12'hDB9, 3'b100);
    check_eq("min_b2b_interval", last_t0[1] - tp, 68);
    pt_valid[1] = 1'b0;
    wait_idle(1);

    check_eq("sclk_outside_cs0", sclk_stray[0], 0);
    check_eq("sclk_outside_cs1", sclk_stray[1], 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
